// File: rtl/r_type_ctrl.sv
// r_type_ctrl: control and register-file stage in front of the R-type ALU.
// It accepts one instruction at a time over valid/ready and walks it through
// DECODE, EXEC and WB. Operands, opcode and flags are held in registers so the
// external combinational ALU sees stable inputs. A debug port loads and
// inspects the 32-entry register file while the stage is idle.
module r_type_ctrl (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        INST_VALID,
  input  logic [31:0] INST,
  output logic        INST_READY,
  output logic [3:0]  ALU_OP,
  output logic [31:0] A,
  output logic [31:0] B,
  input  logic [31:0] F,
  input  logic        ZF,
  input  logic        OF,
  input  logic        SF,
  input  logic        CF,
  input  logic        PF,
  output logic [4:0]  FLAGS,
  output logic        DONE,
  output logic        ILLEGAL,
  input  logic        DBG_WE,
  input  logic [4:0]  DBG_ADDR,
  input  logic [31:0] DBG_WDATA,
  output logic [31:0] DBG_RDATA
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DECODE = 2'd1,
    EXEC   = 2'd2,
    WB     = 2'd3
  } state_t;

  state_t      state;
  logic [31:0] gpr [32];
  logic [4:0]  rs_q;
  logic [4:0]  rt_q;
  logic [4:0]  rd_q;
  logic [3:0]  code_q;
  logic        legal_q;
  logic [31:0] result;
  logic [3:0]  in_code;
  logic        in_legal;
  logic [31:0] rs_data;
  logic [31:0] rt_data;
  logic        unused_shamt;

  // The shift-amount field is not part of any supported operation.
  assign unused_shamt = ^INST[10:6];

  // Ready only while idle and out of reset; a handshake is accepted at that edge.
  assign INST_READY = rst_n && (state == IDLE);

  // Register 0 is hard-wired to zero on every read path.
  assign rs_data   = (rs_q == 5'd0) ? 32'd0 : gpr[rs_q];
  assign rt_data   = (rt_q == 5'd0) ? 32'd0 : gpr[rt_q];
  assign DBG_RDATA = (DBG_ADDR == 5'd0) ? 32'd0 : gpr[DBG_ADDR];

  // Decode the offered word so legality is known at the acceptance edge and
  // ILLEGAL can be raised during the DECODE cycle.
  always_comb begin
    in_code  = 4'b0000;
    in_legal = 1'b0;
    if (INST[31:26] == 6'd0) begin
      in_legal = 1'b1;
      case (INST[5:0])
        6'h24:   in_code = 4'b0000;
        6'h25:   in_code = 4'b0001;
        6'h26:   in_code = 4'b0010;
        6'h27:   in_code = 4'b0011;
        6'h20:   in_code = 4'b0100;
        6'h22:   in_code = 4'b0101;
        6'h2B:   in_code = 4'b0110;
        6'h04:   in_code = 4'b0111;
        default: in_legal = 1'b0;
      endcase
    end
  end

  // Instruction sequencing FSM with registered operands, opcode, flags and pulses.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state   <= IDLE;
      rs_q    <= 5'd0;
      rt_q    <= 5'd0;
      rd_q    <= 5'd0;
      code_q  <= 4'b0000;
      legal_q <= 1'b0;
      ALU_OP  <= 4'b0000;
      A       <= 32'd0;
      B       <= 32'd0;
      result  <= 32'd0;
      FLAGS   <= 5'd0;
      DONE    <= 1'b0;
      ILLEGAL <= 1'b0;
    end else begin
      DONE    <= 1'b0;
      ILLEGAL <= 1'b0;
      case (state)
        IDLE: begin
          if (INST_VALID) begin
            rs_q    <= INST[25:21];
            rt_q    <= INST[20:16];
            rd_q    <= INST[15:11];
            code_q  <= in_code;
            legal_q <= in_legal;
            ILLEGAL <= !in_legal;
            state   <= DECODE;
          end
        end
        DECODE: begin
          if (legal_q) begin
            A      <= rs_data;
            B      <= rt_data;
            ALU_OP <= code_q;
            state  <= EXEC;
          end else begin
            state <= IDLE;
          end
        end
        EXEC: begin
          result <= F;
          FLAGS  <= {ZF, OF, SF, CF, PF};
          DONE   <= 1'b1;
          state  <= WB;
        end
        WB: begin
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Register file: writeback in WB, debug writes only while idle; r0 never written.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < 32; i++) begin
        gpr[i] <= 32'd0;
      end
    end else if (state == WB) begin
      if (rd_q != 5'd0) begin
        gpr[rd_q] <= result;
      end
    end else if (state == IDLE && DBG_WE && DBG_ADDR != 5'd0) begin
      gpr[DBG_ADDR] <= DBG_WDATA;
    end
  end

endmodule
